rr_arbiter8: RTL and testbench

Round-robin arbiter that shares one resource among eight requesters. It sequences ownership with a registered one-hot grant: a 3-bit winner index is decoded to an 8-bit one-hot vector, so `gnt_idx = k` drives `gnt = 1 << k`. It sits in front of any shared datapath element (bus, memory port, decoder-driven select) and guarantees fair, mutually exclusive access, with an optional hold timeout.

---
 rtl/rr_arbiter8.sv | 109 ++++++++++
 tb/tb_rr_arbiter8.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: eight-way round-robin arbiter with a registered one-hot grant.
// A rotating pointer sets where the next winner search starts. The owner
// keeps the grant until it releases, withdraws its request or, optionally,
// exceeds MAX_HOLD cycles.
// Optional feature macro: RR_ARB8_TIMEOUT_EN (hold timeout and timeout pulse).
// The owner-done input is named release_gnt because "release" is a reserved
// SystemVerilog keyword and cannot be used as a plain identifier.
module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       release_gnt,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  // Reject illegal hold limits at elaboration time.
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_arbiter8: MAX_HOLD must be in 1..255");
  end

  logic [0:0] state;
  logic [2:0] ptr;
  logic [2:0] winner;
  logic       any_req;
  logic       hold_expired;
  logic       force_revoke;
  logic       end_grant;

  // Winner search: the lowest offset from ptr with a set request wins, so
  // scan the offsets from the farthest to the nearest and let the last hit stand.
  always_comb begin
    winner  = ptr;
    any_req = |req;
    for (int i = 7; i >= 0; i--) begin
      if (req[ptr + 3'(i)]) begin
        winner = ptr + 3'(i);
      end
    end
  end

`ifdef RR_ARB8_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD + 1);
  logic [CW-1:0] hold_cnt;

  // Hold counter: cleared while idle, counts busy cycles and saturates at MAX_HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (state == IDLE) begin
      hold_cnt <= '0;
    end else if (hold_cnt != CW'(MAX_HOLD)) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

  // The grant has been visible for MAX_HOLD cycles once the count reaches MAX_HOLD-1.
  assign hold_expired = (state == BUSY) && (hold_cnt >= CW'(MAX_HOLD - 1));
  assign force_revoke = hold_expired && !release_gnt && req[gnt_idx];
`else
  assign hold_expired = 1'b0;
  assign force_revoke = 1'b0;
`endif

  assign end_grant = release_gnt || !req[gnt_idx] || hold_expired;

  // Main sequencer: grant in IDLE, hold or end the grant in BUSY.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      gnt       <= 8'h00;
      gnt_idx   <= 3'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          timeout <= 1'b0;
          if (any_req) begin
            gnt_idx   <= winner;
            gnt       <= 8'h01 << winner;
            gnt_valid <= 1'b1;
            state     <= BUSY;
          end
        end
        default: begin
          if (end_grant) begin
            gnt       <= 8'h00;
            gnt_valid <= 1'b0;
            ptr       <= gnt_idx + 3'd1;
            timeout   <= force_revoke;
            state     <= IDLE;
          end else begin
            timeout <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: directed vectors for rr_arbiter8 with a queue scoreboard.
// Stimulus is applied on the falling edge and pushes the response expected
// after the next rising edge; a monitor pops and compares just after that edge.
module tb_rr_arbiter8;

`ifdef RR_ARB8_TIMEOUT_EN
  localparam int unsigned HOLD = 4;
`else
  localparam int unsigned HOLD = 16;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       rel;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  typedef struct {
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       valid;
    logic       tmo;
    logic       chk_idx;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  rr_arbiter8 #(.MAX_HOLD(HOLD)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .release_gnt(rel),
    .gnt        (gnt),
    .gnt_idx    (gnt_idx),
    .gnt_valid  (gnt_valid),
    .timeout    (timeout)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs and record the response expected after the next edge.
  task automatic applyStimulus(input logic r, input logic [7:0] rq, input logic rl,
                               input logic [7:0] eg, input logic [2:0] ei,
                               input logic ev, input logic et, input logic ci,
                               input string nm);
    exp_t e;
    @(negedge clk);
    rst = r;
    req = rq;
    rel = rl;
    e.gnt = eg; e.idx = ei; e.valid = ev; e.tmo = et; e.chk_idx = ci; e.name = nm;
    sb.push_back(e);
  endtask

  // Compare the outputs present now against one scoreboard entry.
  task automatic checkOutput(input exp_t e);
    logic ok;
    ok = (gnt === e.gnt) && (gnt_valid === e.valid) && (timeout === e.tmo) &&
         (!e.chk_idx || (gnt_idx === e.idx));
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL %s: got gnt=%h idx=%0d valid=%b tmo=%b, want gnt=%h idx=%0d valid=%b tmo=%b",
               e.name, gnt, gnt_idx, gnt_valid, timeout, e.gnt, e.idx, e.valid, e.tmo);
    end
  endtask

  // Monitor: just after every rising edge, check the oldest pending expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) checkOutput(sb.pop_front());
    end
  end

  // Directed stimulus.
  initial begin
    rst = 1'b1;
    req = 8'h00;
    rel = 1'b0;

    // Reset held with every request active.
    applyStimulus(1, 8'hFF, 0, 8'h00, 3'd0, 0, 0, 1, "reset_0");
    applyStimulus(1, 8'hFF, 0, 8'h00, 3'd0, 0, 0, 1, "reset_1");
    applyStimulus(0, 8'hFF, 0, 8'h01, 3'd0, 1, 0, 1, "first_grant_0");
    applyStimulus(0, 8'hFF, 1, 8'h00, 3'd0, 0, 0, 0, "release_0");

    // Fairness: all request, owner released right after each grant.
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(0, 8'hFF, 0, 8'h01 << (k % 8), 3'(k % 8), 1, 0, 1, $sformatf("fair_grant_%0d", k % 8));
      applyStimulus(0, 8'hFF, 1, 8'h00, 3'd0, 0, 0, 0, $sformatf("fair_release_%0d", k % 8));
    end

    // Single requester 5 (ptr = 1).
    applyStimulus(0, 8'h20, 0, 8'h20, 3'd5, 1, 0, 1, "single_grant");
    applyStimulus(0, 8'h20, 0, 8'h20, 3'd5, 1, 0, 1, "single_hold");
    applyStimulus(0, 8'h20, 1, 8'h00, 3'd0, 0, 0, 0, "single_release");
    applyStimulus(0, 8'h20, 0, 8'h20, 3'd5, 1, 0, 1, "single_regrant");
    applyStimulus(0, 8'h20, 1, 8'h00, 3'd0, 0, 0, 0, "single_release2");
    applyStimulus(0, 8'h00, 1, 8'h00, 3'd0, 0, 0, 0, "idle_release_ignored");

    // Wrap and withdrawal (ptr = 6).
    applyStimulus(0, 8'h81, 0, 8'h80, 3'd7, 1, 0, 1, "wrap_grant_7");
    applyStimulus(0, 8'h01, 0, 8'h00, 3'd0, 0, 0, 0, "withdraw_7");
    applyStimulus(0, 8'h01, 0, 8'h01, 3'd0, 1, 0, 1, "wrap_grant_0");
    applyStimulus(0, 8'h00, 0, 8'h00, 3'd0, 0, 0, 0, "withdraw_0");

    // No preemption (ptr = 1).
    applyStimulus(0, 8'h04, 0, 8'h04, 3'd2, 1, 0, 1, "np_grant_2");
    applyStimulus(0, 8'h06, 0, 8'h04, 3'd2, 1, 0, 1, "np_hold_2");
    applyStimulus(0, 8'h02, 0, 8'h00, 3'd0, 0, 0, 0, "np_withdraw_2");
    applyStimulus(0, 8'h02, 0, 8'h02, 3'd1, 1, 0, 1, "np_grant_1");
    applyStimulus(0, 8'h00, 1, 8'h00, 3'd0, 0, 0, 0, "np_release_1");

    // Reset mid-grant (ptr = 2).
    applyStimulus(0, 8'h10, 0, 8'h10, 3'd4, 1, 0, 1, "mid_grant_4");
    applyStimulus(1, 8'h11, 0, 8'h00, 3'd0, 0, 0, 1, "mid_reset");
    applyStimulus(0, 8'h11, 0, 8'h01, 3'd0, 1, 0, 1, "post_reset_grant_0");
    applyStimulus(0, 8'h00, 1, 8'h00, 3'd0, 0, 0, 0, "post_reset_release");

`ifdef RR_ARB8_TIMEOUT_EN
    // Timeout: set ptr = 3, then let requester 3 overstay MAX_HOLD = 4.
    applyStimulus(0, 8'h04, 0, 8'h04, 3'd2, 1, 0, 1, "to_setup_grant_2");
    applyStimulus(0, 8'h04, 1, 8'h00, 3'd0, 0, 0, 0, "to_setup_release");
    applyStimulus(0, 8'h0A, 0, 8'h08, 3'd3, 1, 0, 1, "to_grant_3");
    for (int c = 1; c <= 3; c++) begin
      applyStimulus(0, 8'h0A, 0, 8'h08, 3'd3, 1, 0, 1, $sformatf("to_hold_%0d", c));
    end
    applyStimulus(0, 8'h0A, 0, 8'h00, 3'd0, 0, 1, 0, "to_revoke");
    applyStimulus(0, 8'h0A, 0, 8'h02, 3'd1, 1, 0, 1, "to_next_grant_1");
    applyStimulus(0, 8'h00, 1, 8'h00, 3'd0, 0, 0, 0, "to_release_1");
`endif

    // Let the monitor drain, bounded by a few cycles.
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
